// File: rtl/rpn_stack_calc_pkg.sv
// Shared types and the key/mode decoder for the RPN stack calculator.
// Define RPN_MUL_EN to enable the mode-10 K0 multiply; otherwise that key decodes as illegal.
package rpn_pkg;

  typedef enum logic [3:0] {
    OP_PUSH, OP_POP, OP_DUP, OP_SWAP,
    OP_ADD, OP_SUB, OP_AND, OP_OR,
    OP_MUL, OP_XOR, OP_NEG, OP_SHL,
    OP_CLR, OP_ILL
  } op_e;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;

  // key_s is active-low; any pattern other than exactly one pressed key falls to OP_ILL.
  function automatic op_e decode_op(input logic [1:0] mode, input logic [3:0] key_s);
    op_e op;
    op = OP_ILL;
    case ({mode, ~key_s})
      6'b00_0001: op = OP_PUSH;
      6'b00_0010: op = OP_POP;
      6'b00_0100: op = OP_DUP;
      6'b00_1000: op = OP_SWAP;
      6'b01_0001: op = OP_ADD;
      6'b01_0010: op = OP_SUB;
      6'b01_0100: op = OP_AND;
      6'b01_1000: op = OP_OR;
`ifdef RPN_MUL_EN
      6'b10_0001: op = OP_MUL;
`endif
      6'b10_0010: op = OP_XOR;
      6'b10_0100: op = OP_NEG;
      6'b10_1000: op = OP_SHL;
      6'b11_0010: op = OP_CLR;
      default:    op = OP_ILL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rpn_stack_calc_if.sv
// Front-panel bundle of the RPN calculator: switch/key inputs and display/LED outputs.
interface rpn_stack_calc_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [1:0]       mode;
  logic [3:0]       key;
  logic [WIDTH-1:0] val;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             unf;
  logic             ill;

  modport master (output mode, key, val, input top, next, count, ovf, unf, ill);
  modport slave  (input mode, key, val, output top, next, count, ovf, unf, ill);
endinterface

// File: rtl/rpn_stack_calc_regfile.sv
// Stack storage: two asynchronous read ports and two synchronous write ports, no reset.
module rpn_regfile #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    ra0,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [WIDTH-1:0] wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [WIDTH-1:0] wd1
);
  logic [WIDTH-1:0] mem [DEPTH];

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end
endmodule

// File: rtl/rpn_stack_calc.sv
// RPN stack calculator: key synchronizer, press-once FSM, stack pointer, ALU and sticky flags.
// Optional multiply is enabled by defining RPN_MUL_EN.
module rpn_stack_calc
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input logic             clk,
  input logic             rst,
  rpn_stack_calc_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [3:0]       key_m, key_s;
  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] val_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, unf_q, ill_q, ovf_d, unf_d, ill_d;

  logic [PTR_W-1:0] ptr_free, ptr_top, ptr_next;
  logic [WIDTH-1:0] a, b, alu_res;
  logic             empty, lt2, is_bin;
  logic             we0, we1;
  logic [PTR_W-1:0] wa0, wa1;
  logic [WIDTH-1:0] wd0, wd1;

  assign ptr_free = PTR_W'(count_q);
  assign ptr_top  = PTR_W'(count_q - CNT_W'(1));
  assign ptr_next = PTR_W'(count_q - CNT_W'(2));
  assign empty    = (count_q == '0);
  assign lt2      = (count_q < CNT_W'(2));

  rpn_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PTR_W)) u_regfile (
    .clk (clk),
    .ra0 (ptr_top),
    .ra1 (ptr_next),
    .rd0 (a),
    .rd1 (b),
    .we0 (we0),
    .wa0 (wa0),
    .wd0 (wd0),
    .we1 (we1),
    .wa1 (wa1),
    .wd1 (wd1)
  );

  // Slots above count may hold stale data, so mask them rather than show them.
  assign bus.top   = empty ? '0 : a;
  assign bus.next  = lt2 ? '0 : b;
  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
  assign bus.ill   = ill_q;

  always_comb begin
    alu_res = '0;
    is_bin  = 1'b1;
    unique case (op_q)
      OP_ADD:  alu_res = b + a;
      OP_SUB:  alu_res = b - a;
      OP_AND:  alu_res = b & a;
      OP_OR:   alu_res = b | a;
`ifdef RPN_MUL_EN
      OP_MUL:  alu_res = b * a;
`endif
      OP_XOR:  alu_res = b ^ a;
      OP_SHL:  alu_res = b << a[SH_W-1:0];
      OP_NEG: begin
        alu_res = ~a + WIDTH'(1);
        is_bin  = 1'b0;
      end
      default: is_bin = 1'b0;
    endcase
  end

  // Every error path leaves the stack untouched and only raises its flag.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    ill_d   = ill_q;
    we0     = 1'b0;
    wa0     = ptr_top;
    wd0     = alu_res;
    we1     = 1'b0;
    wa1     = ptr_next;
    wd1     = a;
    unique case (op_q)
      OP_PUSH: begin
        if (count_q == FULL) ovf_d = 1'b1;
        else begin
          we0     = 1'b1;
          wa0     = ptr_free;
          wd0     = val_q;
          count_d = count_q + CNT_W'(1);
        end
      end
      OP_POP: begin
        if (empty) unf_d = 1'b1;
        else count_d = count_q - CNT_W'(1);
      end
      OP_DUP: begin
        if (empty) unf_d = 1'b1;
        else if (count_q == FULL) ovf_d = 1'b1;
        else begin
          we0     = 1'b1;
          wa0     = ptr_free;
          wd0     = a;
          count_d = count_q + CNT_W'(1);
        end
      end
      OP_SWAP: begin
        if (lt2) unf_d = 1'b1;
        else begin
          we0 = 1'b1;
          wd0 = b;
          we1 = 1'b1;
        end
      end
      OP_NEG: begin
        if (empty) unf_d = 1'b1;
        else we0 = 1'b1;
      end
      OP_CLR: begin
        count_d = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        ill_d   = 1'b0;
      end
      default: begin
        if (!is_bin) ill_d = 1'b1;
        else if (lt2) unf_d = 1'b1;
        else begin
          we0     = 1'b1;
          wa0     = ptr_next;
          count_d = count_q - CNT_W'(1);
        end
      end
    endcase
    if (state != EXEC) begin
      we0 = 1'b0;
      we1 = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_m   <= 4'hF;
      key_s   <= 4'hF;
      state   <= IDLE;
      op_q    <= OP_ILL;
      val_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      key_m <= bus.key;
      key_s <= key_m;
      unique case (state)
        IDLE: begin
          if (key_s != 4'hF) begin
            op_q  <= decode_op(bus.mode, key_s);
            val_q <= bus.val;
            state <= EXEC;
          end
        end
        EXEC: begin
          count_q <= count_d;
          ovf_q   <= ovf_d;
          unf_q   <= unf_d;
          ill_q   <= ill_d;
          state   <= HOLD;
        end
        HOLD: if (key_s == 4'hF) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rpn_stack_calc.sv
// Directed bench for rpn_stack_calc (WIDTH=16, DEPTH=8); mul expectations follow RPN_MUL_EN.
module tb_rpn_stack_calc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  rpn_stack_calc_if #(.WIDTH(16), .DEPTH(8)) bus ();

  rpn_stack_calc #(.WIDTH(16), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] cnt, input logic [15:0] t,
                             input logic [15:0] n, input logic [2:0] flags);
    check({tag, ".count"}, 32'(bus.count), 32'(cnt));
    check({tag, ".top"}, 32'(bus.top), 32'(t));
    check({tag, ".next"}, 32'(bus.next), 32'(n));
    check({tag, ".flags"}, 32'({bus.ovf, bus.unf, bus.ill}), 32'(flags));
  endtask

  // Drive inputs on the falling edge so the design samples them cleanly.
  task automatic press(input logic [1:0] m, input logic [3:0] k, input logic [15:0] v);
    @(negedge clk);
    bus.mode = m;
    bus.key  = k;
    bus.val  = v;
    repeat (6) @(negedge clk);
    bus.key = 4'hF;
    repeat (4) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] v);
    press(2'b00, 4'b1110, v);
  endtask

  task automatic clr();
    press(2'b11, 4'b1101, 16'h0);
  endtask

  initial begin
    bus.mode = 2'b00;
    bus.key  = 4'hF;
    bus.val  = '0;
    repeat (2) @(negedge clk);
    check_state("reset", 4'd0, 16'h0, 16'h0, 3'b000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset asserted while an op is being held.
    press(2'b00, 4'b1101, 16'h0);
    check_state("t1.pop_empty", 4'd0, 16'h0, 16'h0, 3'b010);
    push(16'h1234);
    @(negedge clk);
    bus.mode = 2'b00;
    bus.key  = 4'b1110;
    bus.val  = 16'h0042;
    repeat (5) @(negedge clk);
    check_state("t1.in_hold", 4'd2, 16'h0042, 16'h1234, 3'b010);
    rst = 1'b1;
    #1;
    check_state("t1.async_rst", 4'd0, 16'h0, 16'h0, 3'b000);
    bus.key = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    push(16'h0007);
    check_state("t1.after_rst", 4'd1, 16'h0007, 16'h0, 3'b000);

    // Subtract with latency check and a long hold.
    clr();
    push(16'h0005);
    push(16'h0003);
    @(negedge clk);
    bus.mode = 2'b01;
    bus.key  = 4'b1101;
    repeat (3) @(posedge clk);
    #1 check("t2.latency_k2", 32'(bus.count), 32'd2);
    @(posedge clk);
    #1 check("t2.latency_k3", 32'(bus.count), 32'd1);
    repeat (17) @(negedge clk);
    check_state("t2.held_once", 4'd1, 16'h0002, 16'h0, 3'b000);
    bus.key = 4'hF;
    repeat (4) @(negedge clk);
    check_state("t2.released", 4'd1, 16'h0002, 16'h0, 3'b000);

    // Wrapping add, multiply (or illegal without the multiplier).
    clr();
    push(16'hFFFF);
    push(16'h0002);
    press(2'b01, 4'b1110, 16'h0);
    check_state("t3.add_wrap", 4'd1, 16'h0001, 16'h0, 3'b000);
    push(16'h0100);
    push(16'h0100);
    press(2'b10, 4'b1110, 16'h0);
`ifdef RPN_MUL_EN
    check_state("t3.mul", 4'd2, 16'h0000, 16'h0001, 3'b000);
`else
    check_state("t6.mul_disabled", 4'd3, 16'h0100, 16'h0100, 3'b001);
`endif

    // Remaining ALU and stack ops.
    clr();
    push(16'h0FF0);
    push(16'h00FF);
    press(2'b01, 4'b1011, 16'h0);
    check_state("and", 4'd1, 16'h00F0, 16'h0, 3'b000);
    push(16'h0F00);
    press(2'b01, 4'b0111, 16'h0);
    check_state("or", 4'd1, 16'h0FF0, 16'h0, 3'b000);
    push(16'hFFFF);
    press(2'b10, 4'b1101, 16'h0);
    check_state("xor", 4'd1, 16'hF00F, 16'h0, 3'b000);
    press(2'b10, 4'b1011, 16'h0);
    check_state("neg", 4'd1, 16'h0FF1, 16'h0, 3'b000);
    push(16'h0004);
    press(2'b10, 4'b0111, 16'h0);
    check_state("shl", 4'd1, 16'hFF10, 16'h0, 3'b000);
    push(16'h0003);
    press(2'b00, 4'b0111, 16'h0);
    check_state("swap", 4'd2, 16'hFF10, 16'h0003, 3'b000);
    press(2'b00, 4'b1011, 16'h0);
    check_state("dup", 4'd3, 16'hFF10, 16'hFF10, 3'b000);
    press(2'b00, 4'b1101, 16'h0);
    check_state("pop", 4'd2, 16'hFF10, 16'h0003, 3'b000);
    press(2'b01, 4'b1101, 16'h0);
    check_state("sub_wrap", 4'd1, 16'h00F3, 16'h0, 3'b000);
    push(16'h0011);
    press(2'b10, 4'b0111, 16'h0);
    check_state("shl_amt_mask", 4'd1, 16'h01E6, 16'h0, 3'b000);

    // Overflow boundary.
    clr();
    for (int i = 1; i <= 8; i++) push(16'(i));
    check_state("t4.full", 4'd8, 16'h0008, 16'h0007, 3'b000);
    push(16'hAAAA);
    check_state("t4.push_ovf", 4'd8, 16'h0008, 16'h0007, 3'b100);
    press(2'b00, 4'b1011, 16'h0);
    check_state("t4.dup_ovf", 4'd8, 16'h0008, 16'h0007, 3'b100);
    clr();
    check_state("t4.clear", 4'd0, 16'h0, 16'h0, 3'b000);

    // Underflow and illegal keys.
    press(2'b00, 4'b1101, 16'h0);
    check_state("t5.pop_unf", 4'd0, 16'h0, 16'h0, 3'b010);
    push(16'h0001);
    press(2'b01, 4'b1110, 16'h0);
    check_state("t5.add_unf", 4'd1, 16'h0001, 16'h0, 3'b010);
    press(2'b00, 4'b1100, 16'h0);
    check_state("t5.two_keys", 4'd1, 16'h0001, 16'h0, 3'b011);
    clr();
    press(2'b11, 4'b1011, 16'h0);
    check_state("t5.mode3_k2", 4'd0, 16'h0, 16'h0, 3'b001);
    clr();
    check_state("t5.clear_empty", 4'd0, 16'h0, 16'h0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
